// File: rtl/router_in_arbiter.sv
// rtl/router_in_arbiter.sv - round-robin store-and-forward ingress scheduler in front of router_top
// Define ROUTER_ARB_PARITY_GEN_EN to generate parity internally instead of forwarding the source parity byte.
module router_in_arbiter #(
  parameter int GAP_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  src_valid,
  input  logic [23:0] src_data,
  output logic [2:0]  src_ready,
  input  logic        busy,
  output logic        pkt_valid,
  output logic [7:0]  rtr_data,
  output logic [2:0]  grant,
  output logic        drop
);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_SEND, S_PARITY, S_GAP} state_t;

  state_t     state, state_next;
  logic [7:0] pkt_buf [64];
  logic [6:0] wr_ptr;
  logic [5:0] rd_ptr;
  logic [5:0] len_q;
  logic [1:0] addr_q;
  logic [7:0] parity_q;
  logic [1:0] grant_idx, last_grant, pick;
  logic [7:0] gap_cnt;

  logic [7:0] src_byte, data_next;
  logic [5:0] cur_len;
  logic [1:0] cur_addr;
  logic [6:0] last_idx;
  logic       take, last_byte, any_req, pv_next, drop_next, rel_grant;

  assign src_ready = (state == S_COLLECT) ? grant : 3'b000;

  always_comb begin
    src_byte = ({8{grant[0]}} & src_data[7:0]) |
               ({8{grant[1]}} & src_data[15:8]) |
               ({8{grant[2]}} & src_data[23:16]);
    take     = (state == S_COLLECT) && (|(src_valid & grant));
    // The header byte is still on the bus when len/addr are needed for it.
    cur_len  = (wr_ptr == 7'd0) ? src_byte[7:2] : len_q;
    cur_addr = (wr_ptr == 7'd0) ? src_byte[1:0] : addr_q;
`ifdef ROUTER_ARB_PARITY_GEN_EN
    last_idx = {1'b0, cur_len};
`else
    last_idx = {1'b0, cur_len} + 7'd1;
`endif
    last_byte = take && (wr_ptr == last_idx);
    any_req   = |src_valid;
    pick      = 2'd0;
    case (last_grant)
      2'd0:    pick = src_valid[1] ? 2'd1 : (src_valid[2] ? 2'd2 : 2'd0);
      2'd1:    pick = src_valid[2] ? 2'd2 : (src_valid[0] ? 2'd0 : 2'd1);
      default: pick = src_valid[0] ? 2'd0 : (src_valid[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    state_next = state;
    pv_next    = 1'b0;
    data_next  = 8'h00;
    drop_next  = 1'b0;
    case (state)
      S_IDLE: if (any_req) state_next = S_COLLECT;
      S_COLLECT: begin
        if (last_byte) begin
          if (cur_addr == 2'd3) begin
            state_next = S_IDLE;
            drop_next  = 1'b1;
          end else begin
            state_next = S_SEND;
            pv_next    = 1'b1;
            data_next  = (wr_ptr == 7'd0) ? src_byte : pkt_buf[0];
          end
        end
      end
      S_SEND: begin
        pv_next   = 1'b1;
        data_next = rtr_data;
        if (!busy) begin
          if (rd_ptr == len_q) begin
            state_next = S_PARITY;
            pv_next    = 1'b0;
            data_next  = parity_q;
          end else begin
            data_next = pkt_buf[rd_ptr + 6'd1];
          end
        end
      end
      S_PARITY: begin
        data_next = rtr_data;
        if (!busy) begin
          data_next  = 8'h00;
          state_next = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: if (gap_cnt == 8'(GAP_CYCLES - 1)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    rel_grant = (state != S_IDLE) && (state_next == S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      grant      <= 3'b000;
      grant_idx  <= 2'd0;
      last_grant <= 2'd2;
      wr_ptr     <= 7'd0;
      rd_ptr     <= 6'd0;
      len_q      <= 6'd0;
      addr_q     <= 2'd0;
      parity_q   <= 8'h00;
      gap_cnt    <= 8'd0;
      pkt_valid  <= 1'b0;
      rtr_data   <= 8'h00;
      drop       <= 1'b0;
    end else begin
      state     <= state_next;
      pkt_valid <= pv_next;
      rtr_data  <= data_next;
      drop      <= drop_next;
      if (state == S_IDLE && any_req) begin
        grant     <= 3'b001 << pick;
        grant_idx <= pick;
        wr_ptr    <= 7'd0;
      end
      if (take) begin
        wr_ptr <= wr_ptr + 7'd1;
        if (wr_ptr == 7'd0) begin
          len_q  <= src_byte[7:2];
          addr_q <= src_byte[1:0];
        end
`ifdef ROUTER_ARB_PARITY_GEN_EN
        parity_q <= (wr_ptr == 7'd0) ? src_byte : (parity_q ^ src_byte);
`else
        if (wr_ptr == last_idx) parity_q <= src_byte;
`endif
      end
      if (state == S_COLLECT) rd_ptr <= 6'd0;
      else if (state == S_SEND && !busy) rd_ptr <= rd_ptr + 6'd1;
      gap_cnt <= (state == S_GAP) ? gap_cnt + 8'd1 : 8'd0;
      if (rel_grant) begin
        last_grant <= grant_idx;
        grant      <= 3'b000;
      end
    end
  end

  // Packet storage is never reset; the write pointer defines what is valid.
  always_ff @(posedge clock) begin
    if (take && (wr_ptr <= {1'b0, cur_len})) pkt_buf[wr_ptr[5:0]] <= src_byte;
  end

endmodule

// File: tb/tb_router_in_arbiter.sv
// tb/tb_router_in_arbiter.sv - self-checking bench for router_in_arbiter
// Honors ROUTER_ARB_PARITY_GEN_EN the same way as the design when building source packets.
module tb_router_in_arbiter;
  localparam int GAP_CYCLES = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  src_valid;
  logic [23:0] src_data;
  logic [2:0]  src_ready;
  logic        busy;
  logic        pkt_valid;
  logic [7:0]  rtr_data;
  logic [2:0]  grant;
  logic        drop;

  router_in_arbiter #(.GAP_CYCLES(GAP_CYCLES)) dut (
    .clock(clock), .reset(reset), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .busy(busy), .pkt_valid(pkt_valid), .rtr_data(rtr_data),
    .grant(grant), .drop(drop)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] v; logic [7:0] d; logic b;
    logic pv; logic [7:0] dat; logic [2:0] g; logic [2:0] rdy; logic drp;
  } vec_t;
  typedef struct { int start; int len; int addr; logic [7:0] par; } rec_t;

  int tests = 0, failed = 0;
  vec_t vecs[$];
  logic [7:0] srcq[3][$];
  int pend[3][$];
  int exp_q[$];
  logic [7:0] cur_pkt[$];
  logic [7:0] allb[$];
  rec_t rec[$];
  logic [2:0] gseq[$];
  int last_model, drops_seen, drops_exp, pv_cycles, hold_a, hold_b;
  int stall_pct = 0, busy_pct = 0, busy_mode = 0;
  logic [2:0] prev_valid, prev_grant;
  bit hold_chk;
  logic hold_pv;
  logic [7:0] hold_d;

  function automatic void check(input bit ok, input string name, input int act, input int req);
    tests++;
    if (!ok) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  function automatic void row(input logic [2:0] v, input logic [7:0] d, input logic b, input logic pv,
                              input logic [7:0] dat, input logic [2:0] g, input logic [2:0] rdy, input logic drp);
    vec_t r;
    r.v = v; r.d = d; r.b = b; r.pv = pv; r.dat = dat; r.g = g; r.rdy = rdy; r.drp = drp;
    vecs.push_back(r);
  endfunction

  function automatic int rr(input logic [2:0] v, input int last);
    for (int i = 1; i <= 3; i++) if (v[(last + i) % 3]) return (last + i) % 3;
    return -1;
  endfunction

  function automatic bit all_drained();
    for (int k = 0; k < 3; k++) if (srcq[k].size() != 0 || pend[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic add_pkt(input int k, input int len, input int addr, input bit bad);
    rec_t r;
    logic [7:0] b, x;
    r.start = allb.size(); r.len = len; r.addr = addr;
    b = {len[5:0], addr[1:0]};
    allb.push_back(b); srcq[k].push_back(b); x = b;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      allb.push_back(b); srcq[k].push_back(b); x = x ^ b;
    end
`ifdef ROUTER_ARB_PARITY_GEN_EN
    r.par = x;
`else
    r.par = bad ? 8'h5A : x;
    srcq[k].push_back(r.par);
`endif
    rec.push_back(r);
    pend[k].push_back(rec.size() - 1);
  endtask

  function automatic void finish_pkt(input logic [7:0] par);
    int idx;
    bit ok;
    if (exp_q.size() == 0) begin
      check(1'b0, "unexpected_pkt", cur_pkt.size(), 0);
      return;
    end
    idx = exp_q.pop_front();
    check(cur_pkt.size() == rec[idx].len + 1, "pkt_len", cur_pkt.size(), rec[idx].len + 1);
    ok = 1'b1;
    for (int i = 0; i < cur_pkt.size() && i <= rec[idx].len; i++)
      if (cur_pkt[i] != allb[rec[idx].start + i]) ok = 1'b0;
    check(ok, "pkt_bytes", idx, idx);
    check(par == rec[idx].par, "parity", par, rec[idx].par);
  endfunction

  task automatic monitor();
    int w, idx;
    if (hold_chk)
      check(pkt_valid == hold_pv && rtr_data == hold_d, "busy_hold", {pkt_valid, rtr_data}, {hold_pv, hold_d});
    if (drop) drops_seen++;
    if (pkt_valid) pv_cycles++;
    if (grant != 3'b000 && prev_grant == 3'b000) begin
      w = rr(prev_valid, last_model);
      gseq.push_back(grant);
      check(w >= 0 && grant == (3'b001 << w), "rr_grant", grant, (w >= 0) ? (1 << w) : 0);
      if (w >= 0) begin
        last_model = w;
        if (pend[w].size() > 0) begin
          idx = pend[w].pop_front();
          if (rec[idx].addr == 3) drops_exp++;
          else exp_q.push_back(idx);
        end else check(1'b0, "grant_without_pkt", w, -1);
      end
    end
    prev_grant = grant;
  endtask

  task automatic drive();
    logic [2:0] v;
    logic [23:0] d;
    logic b;
    v = 3'b000; d = 24'h0; b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d[8*k +: 8] = 8'($urandom);
      if (srcq[k].size() > 0 && int'($urandom_range(99)) >= stall_pct) begin
        v[k] = 1'b1;
        d[8*k +: 8] = srcq[k][0];
      end
    end
    case (busy_mode)
      1: b = int'($urandom_range(99)) < busy_pct;
      2: begin
        if (pkt_valid && cur_pkt.size() == 2 && hold_a < 3) begin b = 1'b1; hold_a++; end
        else if (!pkt_valid && cur_pkt.size() > 0 && hold_b < 3) begin b = 1'b1; hold_b++; end
      end
      default: b = 1'b0;
    endcase
    src_valid = v; src_data = d; busy = b;
    if (!b) begin
      if (pkt_valid) cur_pkt.push_back(rtr_data);
      else if (cur_pkt.size() > 0) begin
        finish_pkt(rtr_data);
        cur_pkt.delete();
      end
    end
    hold_chk = b && (pkt_valid || cur_pkt.size() > 0);
    hold_pv = pkt_valid; hold_d = rtr_data;
    prev_valid = v;
    for (int k = 0; k < 3; k++) if (v[k] && src_ready[k]) void'(srcq[k].pop_front());
  endtask

  task automatic cycle();
    @(negedge clock);
    monitor();
    drive();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; src_valid = 3'b000; src_data = 24'h0; busy = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin srcq[k].delete(); pend[k].delete(); end
    exp_q.delete(); cur_pkt.delete(); gseq.delete();
    last_model = 2; prev_grant = 3'b000; prev_valid = 3'b000; hold_chk = 1'b0;
    drops_seen = 0; drops_exp = 0; pv_cycles = 0; hold_a = 0; hold_b = 0;
  endtask

  task automatic run_until_idle(input int max);
    int n;
    n = 0;
    while (!(all_drained() && exp_q.size() == 0 && cur_pkt.size() == 0 && grant == 3'b000) && n < max) begin
      cycle();
      n++;
    end
    check(n < max, "timeout", n, max);
    repeat (4) cycle();
    check(drops_seen == drops_exp, "drop_count", drops_seen, drops_exp);
    check(exp_q.size() == 0, "pkts_outstanding", exp_q.size(), 0);
  endtask

  initial begin
    int n, len;
    logic [2:0] gexp [4];
    reset = 1'b1; src_valid = 3'b000; src_data = 24'h0; busy = 1'b0;
    do_reset();

    // Cycle-exact single packet: source 0, len=4, addr=1, busy low.
    row(3'b001, 8'h11, 0, 0, 8'h00, 3'b000, 3'b000, 0);
    row(3'b001, 8'h11, 0, 0, 8'h00, 3'b001, 3'b001, 0);
    row(3'b001, 8'hAA, 0, 0, 8'h00, 3'b001, 3'b001, 0);
    row(3'b001, 8'h01, 0, 0, 8'h00, 3'b001, 3'b001, 0);
    row(3'b001, 8'h02, 0, 0, 8'h00, 3'b001, 3'b001, 0);
    row(3'b001, 8'h03, 0, 0, 8'h00, 3'b001, 3'b001, 0);
`ifndef ROUTER_ARB_PARITY_GEN_EN
    row(3'b001, 8'hBB, 0, 0, 8'h00, 3'b001, 3'b001, 0);
`endif
    row(3'b000, 8'h00, 0, 1, 8'h11, 3'b001, 3'b000, 0);
    row(3'b000, 8'h00, 0, 1, 8'hAA, 3'b001, 3'b000, 0);
    row(3'b000, 8'h00, 0, 1, 8'h01, 3'b001, 3'b000, 0);
    row(3'b000, 8'h00, 0, 1, 8'h02, 3'b001, 3'b000, 0);
    row(3'b000, 8'h00, 0, 1, 8'h03, 3'b001, 3'b000, 0);
    row(3'b000, 8'h00, 0, 0, 8'hBB, 3'b001, 3'b000, 0);
    row(3'b000, 8'h00, 0, 0, 8'h00, 3'b001, 3'b000, 0);
    row(3'b000, 8'h00, 0, 0, 8'h00, 3'b001, 3'b000, 0);
    row(3'b000, 8'h00, 0, 0, 8'h00, 3'b000, 3'b000, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      check(pkt_valid == vecs[i].pv, $sformatf("vec%0d_pkt_valid", i), pkt_valid, vecs[i].pv);
      check(rtr_data == vecs[i].dat, $sformatf("vec%0d_rtr_data", i), rtr_data, vecs[i].dat);
      check(grant == vecs[i].g, $sformatf("vec%0d_grant", i), grant, vecs[i].g);
      check(src_ready == vecs[i].rdy, $sformatf("vec%0d_src_ready", i), src_ready, vecs[i].rdy);
      check(drop == vecs[i].drp, $sformatf("vec%0d_drop", i), drop, vecs[i].drp);
      src_valid = vecs[i].v; src_data = {16'h0, vecs[i].d}; busy = vecs[i].b;
    end

    // All three sources requesting at once.
    do_reset();
    add_pkt(0, 2, 1, 0); add_pkt(1, 2, 2, 0); add_pkt(2, 2, 0, 0); add_pkt(0, 2, 1, 0);
    run_until_idle(400);
    gexp = '{3'b001, 3'b010, 3'b100, 3'b001};
    check(gseq.size() == 4, "grant_seq_len", gseq.size(), 4);
    for (int i = 0; i < 4 && i < gseq.size(); i++)
      check(gseq[i] == gexp[i], $sformatf("grant_seq%0d", i), gseq[i], gexp[i]);

    // busy held on the 2nd payload byte and on parity.
    do_reset();
    busy_mode = 2;
    add_pkt(0, 4, 1, 0);
    run_until_idle(200);
    check(hold_a == 3, "busy_payload_cycles", hold_a, 3);
    check(hold_b == 3, "busy_parity_cycles", hold_b, 3);
    busy_mode = 0;

    // addr=3 discard.
    do_reset();
    add_pkt(0, 5, 3, 0);
    run_until_idle(200);
    check(drops_seen == 1, "drop_pulse", drops_seen, 1);
    check(pv_cycles == 0, "drop_no_send", pv_cycles, 0);
    check(srcq[0].size() == 0, "drop_bytes_consumed", srcq[0].size(), 0);

    // Reset in the middle of a long SEND.
    do_reset();
    add_pkt(0, 63, 1, 0);
    n = 0;
    while (!(pkt_valid && cur_pkt.size() >= 20) && n < 300) begin cycle(); n++; end
    check(n < 300, "reach_send", n, 300);
    #2 reset = 1'b1;
    #1;
    check(pkt_valid == 1'b0, "rst_pkt_valid", pkt_valid, 0);
    check(grant == 3'b000, "rst_grant", grant, 0);
    check(src_ready == 3'b000, "rst_src_ready", src_ready, 0);
    do_reset();
    add_pkt(0, 3, 2, 0);
    run_until_idle(200);

    // Corrupt source parity.
    do_reset();
    add_pkt(0, 3, 1, 1);
    run_until_idle(200);

    // Randomised traffic with source stalls and router backpressure.
    do_reset();
    stall_pct = 25; busy_mode = 1; busy_pct = 30;
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 8; p++) begin
        len = ($urandom_range(9) == 0) ? 63 : int'($urandom_range(10));
        add_pkt(int'($urandom_range(2)), len, int'($urandom_range(3)), 1'($urandom_range(1)));
      end
      run_until_idle(6000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
